// File: rtl/pkt_proc_sched_pkg.sv
// pkt_sched_defs: unit bit indices, FSM encoding and lowest-unit helper shared by pkt_proc_sched.
package pkt_sched_defs;
  localparam int JOB_W = 4;
  localparam int UNIT_REWARD = 0;
  localparam int UNIT_QTU = 1;
  localparam int UNIT_MNI = 2;
  localparam int UNIT_KCH = 3;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_e;
  function automatic logic [1:0] low_unit(input logic [JOB_W-1:0] m);
    return m[UNIT_REWARD] ? 2'(UNIT_REWARD) : m[UNIT_QTU] ? 2'(UNIT_QTU) :
           m[UNIT_MNI] ? 2'(UNIT_MNI) : 2'(UNIT_KCH);
  endfunction
endpackage

// File: rtl/pkt_proc_sched_job_fifo.sv
// job_fifo: synchronous FIFO; push ignored when full, pop ignored when empty.
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/pkt_proc_sched.sv
// pkt_proc_sched: queues per-packet unit masks and runs one unit at a time, lowest bit first.
// Optional watchdog on unit completion enabled by defining SCHED_WDOG_EN.
module pkt_proc_sched
  import pkt_sched_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int WDOG_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [JOB_W-1:0]       req_mask,
  input  logic [JOB_W-1:0]       done_i,
  output logic [JOB_W-1:0]       start_o,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   full,
  output logic                   drop,
  output logic                   wdog_err
);
  state_e state_q, state_d;
  logic [JOB_W-1:0] mask_q, mask_d, head;
  logic [1:0] unit_q, unit_d;
  logic pop, empty, drop_q, hit, timeout, finish;
  job_fifo #(.DEPTH(DEPTH), .WIDTH(JOB_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid && |req_mask),
    .data_i  (req_mask),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (q_count)
  );
  assign hit = done_i[unit_q];
  assign finish = state_q == S_WAIT && (hit || timeout);
  assign busy = state_q != S_IDLE;
  assign drop = drop_q;
`ifdef SCHED_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYC) + 1;
  logic [WCW-1:0] wcnt_q;
  logic err_q;
  // a done arriving on the limit cycle wins over the timeout
  assign timeout = !hit && wcnt_q == WCW'(WDOG_CYC - 1);
  assign wdog_err = err_q;
  always_ff @(posedge clk) begin
    wcnt_q <= (rst || state_q != S_WAIT) ? '0 : wcnt_q + 1'b1;
    err_q <= !rst && (err_q || (state_q == S_WAIT && timeout));
  end
`else
  assign timeout = 1'b0;
  assign wdog_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    unit_d = unit_q;
    pop = 1'b0;
    start_o = '0;
    case (state_q)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        mask_d = head;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        unit_d = low_unit(mask_q);
        start_o = JOB_W'(1) << low_unit(mask_q);
        state_d = S_WAIT;
      end
      S_WAIT: if (finish) begin
        mask_d = mask_q & ~(JOB_W'(1) << unit_q);
        state_d = |mask_d ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q <= '0;
      unit_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      unit_q <= unit_d;
      drop_q <= req_valid && |req_mask && full;
    end
  end
endmodule

// File: tb/tb_pkt_proc_sched.sv
// tb_pkt_proc_sched: table vectors, corner sequences and random traffic against a queue-based model.
module tb_pkt_proc_sched;
  localparam int DEPTH = 4;
  localparam int WD = 8;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
  logic [3:0] req_mask = '0, done_i = '0, start_o;
  logic busy, full, drop, wdog_err;
  logic [2:0] q_count;
  pkt_proc_sched #(.DEPTH(DEPTH), .WDOG_CYC(WD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mask(req_mask), .done_i(done_i),
    .start_o(start_o), .busy(busy), .q_count(q_count), .full(full), .drop(drop), .wdog_err(wdog_err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [3:0] m_q[$];
  logic [3:0] m_rem = '0;
  int m_start_at = -10;
  bit m_drop = 0, m_err = 0;
  logic [3:0] s_start;
  logic s_busy, s_full, s_drop, s_err;
  logic [2:0] s_qc;
  typedef struct {
    logic rv; logic [3:0] m, d, es; logic eb; logic [2:0] eq; logic ed;
  } vec_t;
  vec_t tbl[17];
  function automatic logic [3:0] lowbit(input logic [3:0] x);
    return x & (~x + 4'd1);
  endfunction
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask
  // one clock: drive inputs, check outputs against the model, then advance the model
  task automatic step(input logic r, input logic rv, input logic [3:0] m, input logic [3:0] d);
    bit was_full, hit, to;
    logic [3:0] lb;
    @(negedge clk);
    rst = r; req_valid = rv; req_mask = m; done_i = d;
    s_start = start_o; s_busy = busy; s_qc = q_count; s_full = full; s_drop = drop; s_err = wdog_err;
    cmp("start", start_o, (cyc == m_start_at && m_rem != 0) ? lowbit(m_rem) : 4'd0);
    cmp("busy", busy, m_rem != 0);
    cmp("q_count", q_count, m_q.size());
    cmp("full", full, m_q.size() == DEPTH);
    cmp("drop", drop, m_drop);
    cmp("wdog_err", wdog_err, m_err);
    cmp("onehot", $countones(start_o) <= 1, 1);
    if (r) begin
      m_q.delete(); m_rem = '0; m_drop = 0; m_err = 0; m_start_at = -10;
    end else begin
      was_full = m_q.size() == DEPTH;
      lb = lowbit(m_rem);
      if (m_rem == 0) begin
        if (m_q.size() != 0) begin m_rem = m_q.pop_front(); m_start_at = cyc + 1; end
      end else if (cyc > m_start_at) begin
        hit = (d & lb) != 0;
        to = 0;
`ifdef SCHED_WDOG_EN
        to = !hit && (cyc - m_start_at == WD);
`endif
        if (hit || to) begin
          m_err |= to;
          m_rem &= ~lb;
          if (m_rem != 0) m_start_at = cyc + 1;
        end
      end
      m_drop = rv && m != 0 && was_full;
      if (rv && m != 0 && !was_full) m_q.push_back(m);
    end
    cyc++;
  endtask
  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask
  initial begin
    logic [3:0] got[$];
    logic [3:0] exp3[5];
    int t2, t4;
    tbl = '{
      '{1, 4'h5, 4'h0, 4'h0, 0, 0, 0}, '{0, 4'h0, 4'h0, 4'h0, 0, 1, 0},
      '{0, 4'h0, 4'h0, 4'h1, 1, 0, 0}, '{0, 4'h0, 4'h0, 4'h0, 1, 0, 0},
      '{1, 4'h0, 4'h8, 4'h0, 1, 0, 0}, '{0, 4'h0, 4'h1, 4'h0, 1, 0, 0},
      '{0, 4'h0, 4'h0, 4'h4, 1, 0, 0}, '{0, 4'h0, 4'h0, 4'h0, 1, 0, 0},
      '{0, 4'h0, 4'h4, 4'h0, 1, 0, 0}, '{0, 4'h0, 4'h0, 4'h0, 0, 0, 0},
      '{1, 4'h2, 4'h0, 4'h0, 0, 0, 0}, '{0, 4'h0, 4'h0, 4'h0, 0, 1, 0},
      '{0, 4'h0, 4'h0, 4'h2, 1, 0, 0}, '{1, 4'h0, 4'h8, 4'h0, 1, 0, 0},
      '{0, 4'h0, 4'hD, 4'h0, 1, 0, 0}, '{0, 4'h0, 4'h2, 4'h0, 1, 0, 0},
      '{0, 4'h0, 4'h0, 4'h0, 0, 0, 0}
    };
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(0, tbl[i].rv, tbl[i].m, tbl[i].d);
      cmp("tbl_start", s_start, tbl[i].es);
      cmp("tbl_busy", s_busy, tbl[i].eb);
      cmp("tbl_qc", s_qc, tbl[i].eq);
      cmp("tbl_drop", s_drop, tbl[i].ed);
    end
    // full mask: each unit started once, in fixed order
    do_reset();
    step(0, 1, 4'hF, 0);
    got.delete();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, (got.size() != 0 && i % 3 == 0) ? got[$] : 4'h0);
      if (s_start != 0) got.push_back(s_start);
    end
    cmp("order_n", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) cmp("order", got[i], 4'h1 << i);
    // overflow: stall in WAIT, send 6 requests, last two dropped
    do_reset();
    step(0, 1, 4'h1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    exp3 = '{4'h2, 4'h4, 4'h8, 4'h3, 4'hF};
    for (int i = 0; i < 5; i++) step(0, 1, exp3[i], 0);
    step(0, 1, 4'h5, 0);
    cmp("drop5", s_drop, 1);
    step(0, 0, 0, 4'h1);
    cmp("q_full_cnt", s_qc, 4);
    cmp("q_full", s_full, 1);
    cmp("drop6", s_drop, 1);
    exp3 = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    got.delete();
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 4'hF);
      if (s_start != 0) got.push_back(s_start);
    end
    cmp("fifo_n", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) cmp("fifo_order", got[i], exp3[i]);
    // reset mid-job with two jobs queued; late done is ignored
    do_reset();
    step(0, 1, 4'h3, 0);
    step(0, 1, 4'h4, 0);
    step(0, 1, 4'h8, 0);
    step(0, 0, 0, 0);
    cmp("pre_rst_qc", s_qc, 2);
    step(1, 0, 0, 0);
    step(0, 0, 0, 4'hF);
    cmp("rst_out", {s_start, s_busy, s_qc, s_full, s_drop, s_err}, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 4'hF);
      cmp("late_done", {s_start, s_busy}, 0);
    end
`ifdef SCHED_WDOG_EN
    // QTU never completes: abandoned after WD wait cycles, MNI then runs
    do_reset();
    step(0, 1, 4'h6, 0);
    t2 = -1; t4 = -1;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, (t4 >= 0) ? 4'h4 : 4'h0);
      if (s_start == 4'h2) t2 = i;
      if (s_start == 4'h4) t4 = i;
    end
    cmp("wdog_gap", t4 - t2, WD + 1);
    cmp("wdog_sticky", s_err, 1);
    do_reset();
    step(0, 0, 0, 0);
    cmp("wdog_clr", s_err, 0);
`else
    t2 = 0; t4 = 0;
`endif
    do_reset();
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pkt_proc_sched.md
Name: pkt_proc_sched

Overview:
Sequences the per-packet processing units after packetFilter has classified a packet: reward calc, Q-table update (QTU), my-node-info update (MNI) and cluster-head check (KCH). Each packet yields a 4-bit job mask. These units share the node's Q/neighbour memory port, so the scheduler queues the masks and runs at most one unit at a time. It issues each unit a one-cycle start and waits for that unit's done. It sits between packetFilter and the unit datapaths.

Parameters:
DEPTH, 4, job FIFO entries (power of 2, >=2)
WDOG_CYC, 64, watchdog limit in cycles per unit (used only with SCHED_WDOG_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  one-cycle strobe: packet classified, req_mask valid
req_mask  in  4  bit0 en_reward, bit1 en_QTU, bit2 en_MNI, bit3 en_KCH
done_i  in  4  per-unit completion pulse, same bit order
start_o  out  4  one-hot start pulse to the unit, same bit order
busy  out  1  FSM not in IDLE
q_count  out  $clog2(DEPTH)+1  queued jobs, excluding the current job
full  out  1  q_count==DEPTH
drop  out  1  one-cycle pulse: request lost because the FIFO was full
wdog_err  out  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset (rst high at an edge): FIFO emptied; FSM to IDLE; cur_mask=0; start_o=0, busy=0, q_count=0, full=0, drop=0, wdog_err=0.
- Reset mid-job abandons the job. A late done_i arriving after reset is ignored.
- Push: when req_valid=1 and req_mask!=0, the mask is written if q_count<DEPTH.
  - Fullness is judged before any same-cycle pop. A push and a pop in the same cycle are both performed only when not full.
  - If full, the request is discarded and drop=1 on the next cycle.
- req_mask==0 is ignored: no push, no drop.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if FIFO not empty, pop head into cur_mask and go to ISSUE.
  - ISSUE: start_o = one-hot of the lowest set bit of cur_mask, held for exactly this cycle. Record cur_unit. Go to WAIT.
  - WAIT: when done_i[cur_unit]=1, clear that bit of cur_mask. If the remaining mask is nonzero, go to ISSUE; otherwise go to IDLE.
  - IDLE always spends at least one cycle before the next pop.
- Service order within a packet is fixed: reward, QTU, MNI, KCH.
- done_i bits other than cur_unit are ignored. done_i in IDLE or ISSUE is ignored.
- Latency, idle and empty case: req_valid at cycle N gives push at N, pop in IDLE at N+1, and the first start_o at N+2.
  - Next start_o follows one cycle after the matching done_i.
- q_count saturates at neither end; push and pop rules make overflow and underflow impossible.

Optional Feature:
SCHED_WDOG_EN:
- Defined: a counter clears on ISSUE and increments in WAIT.
  - When the counter reaches WDOG_CYC without the matching done, the current unit is abandoned: its bit is cleared, wdog_err is set (sticky until rst), and the FSM proceeds as on done.
  - If done arrives in the same cycle as the limit, it counts as done; no error is raised.
- Undefined: no counter; WAIT waits indefinitely; wdog_err is tied to 0.

Decomposition:
- Shared package/header pkt_sched_defs: unit bit indices (UNIT_REWARD=0, UNIT_QTU=1, UNIT_MNI=2, UNIT_KCH=3), FSM state encodings, JOB_W=4.
- One sub-module, job_fifo: synchronous FIFO with DEPTH and WIDTH parameters, push/pop/full/empty/count. The scheduler instantiates it with WIDTH=4.

Test Plan:
1. Heartbeat packet: req_mask=4'b0101 at cycle 10 -> start_o=0001 at cycle 12. done_i[0] at 15 -> start_o=0100 at 16. done_i[2] at 18 -> busy=0 at 19.
2. Full mask 4'b1111 with done 2 cycles after each start -> starts in order 0001, 0010, 0100, 1000. Exactly one start per unit; start_o never has more than one bit set.
3. With DEPTH=4 and the FSM stalled in WAIT, send 6 requests -> q_count=4, full=1; drop pulses for requests 5 and 6. Then complete all jobs -> 4 jobs served in FIFO order.
4. Stray pulses: done_i[3] during QTU's WAIT, and req_mask=0 -> both ignored; state and q_count unchanged; no drop.
5. Reset mid-job: rst asserted during WAIT with 2 jobs queued -> next cycle all outputs 0. A done_i after reset causes no start.
6. SCHED_WDOG_EN, WDOG_CYC=8: never return done_i[1] -> QTU abandoned after 8 WAIT cycles, wdog_err=1, next unit started; wdog_err stays 1 until rst.
